// File: rtl/camera64x64_reader.sv
// camera64x64_reader
// Host-side SPI read master for the 64x64 camera. It waits for the camera
// interrupt, clocks one full frame in over SCLK/MISO, and presents each pixel
// as a byte with its index. After the last pixel, SCLK is parked low for a
// quiet gap so the camera sees the burst end and re-arms its interrupt.
//
// Parameters
//   CLKDIV  : SCLK half-period in CLK cycles (2..255)
//   PIXELS  : pixels per frame (1..4096)
//   TIMEOUT : CLK cycles to wait for INT before flagging ERR (0 disables)
//
// Ports
//   CLK, RST      : system clock, asynchronous active-high reset
//   ENABLE        : level, arms the reader for frames while high
//   INT, LOOKUP   : camera interrupt / lookup flag (asynchronous inputs)
//   MISO          : camera serial data (asynchronous input)
//   SCLK          : registered SPI clock, idle low
//   PIX_VALID     : one-cycle strobe qualifying PIX_DATA / PIX_ADDR
//   PIX_DATA      : pixel byte, MSB first on the wire
//   PIX_ADDR      : pixel index within the frame
//   FRAME_DONE    : one-cycle strobe at the end of the post-frame gap
//   FRAME_LOOKUP  : synchronized LOOKUP captured with FRAME_DONE
//   BUSY          : high while a frame is being transferred or in its gap
//   ERR           : sticky interrupt timeout flag, cleared by ENABLE low
module camera64x64_reader #(
  parameter int unsigned CLKDIV  = 4,
  parameter int unsigned PIXELS  = 4096,
  parameter logic [31:0] TIMEOUT = 32'h00010000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        INT,
  input  logic        LOOKUP,
  input  logic        MISO,
  output logic        SCLK,
  output logic        PIX_VALID,
  output logic [7:0]  PIX_DATA,
  output logic [11:0] PIX_ADDR,
  output logic        FRAME_DONE,
  output logic        FRAME_LOOKUP,
  output logic        BUSY,
  output logic        ERR
);

  localparam logic [7:0]  DIV_LAST = 8'(CLKDIV - 1);
  localparam logic [11:0] PIX_LAST = 12'(PIXELS - 1);
  localparam logic [11:0] GAP_LAST = 12'(16 * CLKDIV - 1);
  localparam logic [31:0] TO_LAST  = TIMEOUT - 32'd1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_INT,
    XFER,
    GAP
  } state_t;

  state_t      state;
  logic        int_meta;
  logic        int_s;
  logic        int_prev;
  logic        int_edge;
  logic        lookup_meta;
  logic        lookup_s;
  logic        miso_meta;
  logic        miso_s;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic [11:0] pix_cnt;
  logic [11:0] gap_cnt;
  logic [31:0] to_cnt;
  logic [7:0]  shift_reg;
  logic [7:0]  sample;

  // The byte as it stands once the current MISO bit is shifted in; used both
  // to advance the shift register and to publish a completed pixel.
  assign sample = {shift_reg[6:0], miso_s};

  // Two-flop synchronizers for the three camera inputs, plus a registered
  // rising-edge detect on INT. Tracking int_prev in every state means a level
  // that is already high when WAIT_INT is entered never looks like an edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      int_meta    <= 1'b0;
      int_s       <= 1'b0;
      int_prev    <= 1'b0;
      int_edge    <= 1'b0;
      lookup_meta <= 1'b0;
      lookup_s    <= 1'b0;
      miso_meta   <= 1'b0;
      miso_s      <= 1'b0;
    end else begin
      int_meta    <= INT;
      int_s       <= int_meta;
      int_prev    <= int_s;
      int_edge    <= int_s & ~int_prev;
      lookup_meta <= LOOKUP;
      lookup_s    <= lookup_meta;
      miso_meta   <= MISO;
      miso_s      <= miso_meta;
    end
  end

  // Main controller. WAIT_INT runs the interrupt timeout; XFER divides CLK
  // down to SCLK and samples MISO on every SCLK fall, publishing a pixel per
  // eight samples; GAP holds SCLK low for 16 half-periods before reporting
  // the frame. Once XFER starts, ENABLE is not consulted until GAP ends, so a
  // frame always completes. The ERR clear sits after the case so that it
  // overrides a timeout set in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      SCLK         <= 1'b0;
      PIX_VALID    <= 1'b0;
      PIX_DATA     <= 8'd0;
      PIX_ADDR     <= 12'd0;
      FRAME_DONE   <= 1'b0;
      FRAME_LOOKUP <= 1'b0;
      BUSY         <= 1'b0;
      ERR          <= 1'b0;
      div_cnt      <= 8'd0;
      bit_cnt      <= 3'd0;
      pix_cnt      <= 12'd0;
      gap_cnt      <= 12'd0;
      to_cnt       <= 32'd0;
      shift_reg    <= 8'd0;
    end else begin
      PIX_VALID  <= 1'b0;
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= 32'd0;
          if (ENABLE) begin
            state <= WAIT_INT;
          end
        end

        WAIT_INT: begin
          if (!ENABLE) begin
            state  <= IDLE;
            to_cnt <= 32'd0;
          end else if (int_edge) begin
            state     <= XFER;
            BUSY      <= 1'b1;
            to_cnt    <= 32'd0;
            div_cnt   <= 8'd0;
            bit_cnt   <= 3'd0;
            pix_cnt   <= 12'd0;
            shift_reg <= 8'd0;
            PIX_ADDR  <= 12'd0;
          end else if (TIMEOUT != 32'd0) begin
            if (to_cnt == TO_LAST) begin
              ERR    <= 1'b1;
              to_cnt <= 32'd0;
            end else begin
              to_cnt <= to_cnt + 32'd1;
            end
          end
        end

        XFER: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            SCLK    <= ~SCLK;
            if (SCLK) begin
              shift_reg <= sample;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                PIX_DATA  <= sample;
                PIX_ADDR  <= pix_cnt;
                PIX_VALID <= 1'b1;
                bit_cnt   <= 3'd0;
                pix_cnt   <= pix_cnt + 12'd1;
                if (pix_cnt == PIX_LAST) begin
                  state   <= GAP;
                  gap_cnt <= 12'd0;
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt      <= 12'd0;
            FRAME_DONE   <= 1'b1;
            FRAME_LOOKUP <= lookup_s;
            BUSY         <= 1'b0;
            state        <= ENABLE ? WAIT_INT : IDLE;
          end else begin
            gap_cnt <= gap_cnt + 12'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      if (!ENABLE) begin
        ERR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_camera64x64_reader.sv
// tb_camera64x64_reader
// Directed bench for camera64x64_reader with CLKDIV=4, PIXELS=4, TIMEOUT=100.
// A small camera model drives MISO on SCLK rises from a fixed 4-byte pattern
// and toggles LOOKUP at the start of each 32-bit burst. A negedge monitor logs
// pixels, frame completions and SCLK phase lengths for the directed checks.
module tb_camera64x64_reader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b0;
  logic        INT = 1'b0;
  logic        LOOKUP = 1'b0;
  logic        MISO = 1'b0;
  logic        SCLK;
  logic        PIX_VALID;
  logic [7:0]  PIX_DATA;
  logic [11:0] PIX_ADDR;
  logic        FRAME_DONE;
  logic        FRAME_LOOKUP;
  logic        BUSY;
  logic        ERR;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic       model_clear = 1'b0;
  logic       sclk_prev = 1'b0;
  logic [7:0] model_byte;
  int         bit_idx = 0;
  int         phase_bad = 0;
  int         both_bad = 0;
  int         last_edge_cyc = 0;
  int         last_fall_cyc = 0;
  int         first_rise_cyc = 0;
  int         int_cyc = 0;
  int         pix_base = 0;
  int         done_base = 0;

  logic [7:0]  pattern [0:3] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
  logic [7:0]  pix_data_log [0:63];
  logic [11:0] pix_addr_log [0:63];
  int          pix_seen = 0;
  logic        lookup_log [0:15];
  int          done_gap_log [0:15];
  int          done_seen = 0;

  camera64x64_reader #(
    .CLKDIV (4),
    .PIXELS (4),
    .TIMEOUT(32'd100)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ENABLE      (ENABLE),
    .INT         (INT),
    .LOOKUP      (LOOKUP),
    .MISO        (MISO),
    .SCLK        (SCLK),
    .PIX_VALID   (PIX_VALID),
    .PIX_DATA    (PIX_DATA),
    .PIX_ADDR    (PIX_ADDR),
    .FRAME_DONE  (FRAME_DONE),
    .FRAME_LOOKUP(FRAME_LOOKUP),
    .BUSY        (BUSY),
    .ERR         (ERR)
  );

  // 10 ns system clock and a cycle counter indexed by posedge.
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc = cyc + 1;
  end

  // Camera model and output monitor, evaluated on the falling CLK edge so all
  // DUT outputs have settled. SCLK rises present the next MISO bit, MSB first;
  // each SCLK phase inside a burst must last exactly 4 CLK cycles.
  always @(negedge CLK) begin
    if (model_clear) begin
      bit_idx = 0;
      LOOKUP  = 1'b0;
      MISO    = 1'b0;
    end else begin
      if (SCLK && !sclk_prev) begin
        if (bit_idx % 32 == 0) begin
          LOOKUP = ~LOOKUP;
          if (bit_idx == 0) begin
            first_rise_cyc = cyc;
          end
        end else if (cyc - last_edge_cyc != 4) begin
          phase_bad++;
        end
        model_byte = pattern[(bit_idx / 8) % 4];
        MISO = model_byte[7 - (bit_idx % 8)];
        bit_idx++;
        last_edge_cyc = cyc;
      end
      if (!SCLK && sclk_prev) begin
        if (cyc - last_edge_cyc != 4) begin
          phase_bad++;
        end
        last_edge_cyc = cyc;
        last_fall_cyc = cyc;
      end
    end
    sclk_prev = SCLK;
    if (PIX_VALID && pix_seen < 64) begin
      pix_data_log[pix_seen] = PIX_DATA;
      pix_addr_log[pix_seen] = PIX_ADDR;
      pix_seen++;
    end
    if (FRAME_DONE && done_seen < 16) begin
      lookup_log[done_seen]   = FRAME_LOOKUP;
      done_gap_log[done_seen] = cyc - last_fall_cyc;
      done_seen++;
    end
    if (PIX_VALID && FRAME_DONE) begin
      both_bad++;
    end
  end

  // Advance n clock cycles and land 1 ns after the last rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive ENABLE and INT, then hold them for the given number of cycles.
  task automatic applyStimulus(input logic en, input logic int_level, input int hold);
    ENABLE = en;
    INT    = int_level;
    tick(hold);
  endtask

  // Put the camera model back to the start of a burst with LOOKUP low.
  task automatic clearModel();
    model_clear = 1'b1;
    tick(1);
    model_clear = 1'b0;
  endtask

  task automatic waitDone(input int target, input int limit);
    int n = 0;
    while (done_seen < target && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  task automatic waitPix(input int target, input int limit);
    int n = 0;
    while (pix_seen < target && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  // Hard stop so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] camera64x64_reader bench start");

    // Reset values while RST is held.
    tick(3);
    checkOutput("rst_sclk",      32'(SCLK),         32'd0);
    checkOutput("rst_pix_valid", 32'(PIX_VALID),    32'd0);
    checkOutput("rst_pix_data",  32'(PIX_DATA),     32'd0);
    checkOutput("rst_pix_addr",  32'(PIX_ADDR),     32'd0);
    checkOutput("rst_done",      32'(FRAME_DONE),   32'd0);
    checkOutput("rst_lookup",    32'(FRAME_LOOKUP), 32'd0);
    checkOutput("rst_busy",      32'(BUSY),         32'd0);
    checkOutput("rst_err",       32'(ERR),          32'd0);
    RST = 1'b0;
    tick(2);

    // Basic frame: A5, 3C, FF, 00 at addresses 0..3.
    clearModel();
    applyStimulus(1'b1, 1'b0, 3);
    int_cyc = cyc;
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1);
    waitDone(1, 1000);
    checkOutput("basic_done_count", 32'(done_seen), 32'd1);
    checkOutput("basic_int_to_sclk", 32'(first_rise_cyc - int_cyc), 32'd8);
    checkOutput("basic_sclk_rises", 32'(bit_idx), 32'd32);
    checkOutput("basic_phase_len", 32'(phase_bad), 32'd0);
    checkOutput("basic_pix_count", 32'(pix_seen), 32'd4);
    checkOutput("basic_addr0", 32'(pix_addr_log[0]), 32'd0);
    checkOutput("basic_data0", 32'(pix_data_log[0]), 32'hA5);
    checkOutput("basic_addr1", 32'(pix_addr_log[1]), 32'd1);
    checkOutput("basic_data1", 32'(pix_data_log[1]), 32'h3C);
    checkOutput("basic_addr2", 32'(pix_addr_log[2]), 32'd2);
    checkOutput("basic_data2", 32'(pix_data_log[2]), 32'hFF);
    checkOutput("basic_addr3", 32'(pix_addr_log[3]), 32'd3);
    checkOutput("basic_data3", 32'(pix_data_log[3]), 32'h00);
    checkOutput("basic_done_gap", 32'(done_gap_log[0]), 32'd64);
    checkOutput("basic_lookup", 32'(lookup_log[0]), 32'd1);
    tick(2);
    checkOutput("basic_busy_after", 32'(BUSY), 32'd0);

    // Back-to-back frames: LOOKUP toggles per burst, no SCLK during GAP.
    clearModel();
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1);
    waitDone(2, 1000);
    checkOutput("b2b_rises_f1", 32'(bit_idx), 32'd32);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1);
    waitDone(3, 1000);
    checkOutput("b2b_done_count", 32'(done_seen), 32'd3);
    checkOutput("b2b_lookup_f1", 32'(lookup_log[1]), 32'd1);
    checkOutput("b2b_lookup_f2", 32'(lookup_log[2]), 32'd0);
    checkOutput("b2b_rises_total", 32'(bit_idx), 32'd64);
    checkOutput("b2b_f2_addr0", 32'(pix_addr_log[8]), 32'd0);
    checkOutput("b2b_f2_data1", 32'(pix_data_log[9]), 32'h3C);
    checkOutput("b2b_f2_addr3", 32'(pix_addr_log[11]), 32'd3);
    checkOutput("b2b_done_gap", 32'(done_gap_log[2]), 32'd64);

    // INT already high when ENABLE rises must not start a transfer.
    applyStimulus(1'b0, 1'b0, 3);
    clearModel();
    applyStimulus(1'b0, 1'b1, 5);
    applyStimulus(1'b1, 1'b1, 40);
    checkOutput("level_int_busy", 32'(BUSY), 32'd0);
    checkOutput("level_int_rises", 32'(bit_idx), 32'd0);
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("level_int_started", 32'(BUSY), 32'd1);
    waitDone(4, 1000);
    checkOutput("level_int_done", 32'(done_seen), 32'd4);
    checkOutput("level_int_frame_rises", 32'(bit_idx), 32'd32);

    // Timeout with no INT: ERR rises exactly 100 cycles into WAIT_INT.
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("to_err_idle", 32'(ERR), 32'd0);
    ENABLE = 1'b1;
    tick(1);
    tick(99);
    checkOutput("to_err_before", 32'(ERR), 32'd0);
    tick(1);
    checkOutput("to_err_set", 32'(ERR), 32'd1);
    checkOutput("to_busy", 32'(BUSY), 32'd0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("to_err_cleared", 32'(ERR), 32'd0);

    // Reset asserted during pixel 2, then a fresh frame from address 0.
    applyStimulus(1'b1, 1'b0, 2);
    clearModel();
    pix_base = pix_seen;
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1);
    waitPix(pix_base + 2, 1000);
    checkOutput("rst_mid_pix_reached", 32'(pix_seen - pix_base), 32'd2);
    tick(10);
    for (int i = 0; i < 10 && !SCLK; i++) begin
      tick(1);
    end
    checkOutput("rst_mid_sclk_high", 32'(SCLK), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("rst_mid_sclk", 32'(SCLK), 32'd0);
    checkOutput("rst_mid_addr", 32'(PIX_ADDR), 32'd0);
    checkOutput("rst_mid_data", 32'(PIX_DATA), 32'd0);
    checkOutput("rst_mid_busy", 32'(BUSY), 32'd0);
    tick(2);
    RST = 1'b0;
    clearModel();
    pix_base  = pix_seen;
    done_base = done_seen;
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1);
    waitDone(done_base + 1, 1000);
    checkOutput("rst_restart_done", 32'(done_seen - done_base), 32'd1);
    checkOutput("rst_restart_pix", 32'(pix_seen - pix_base), 32'd4);
    checkOutput("rst_restart_addr0", 32'(pix_addr_log[pix_base]), 32'd0);
    checkOutput("rst_restart_data0", 32'(pix_data_log[pix_base]), 32'hA5);
    checkOutput("rst_restart_addr3", 32'(pix_addr_log[pix_base + 3]), 32'd3);

    // ENABLE dropped mid-frame: frame completes, then INT is ignored.
    clearModel();
    pix_base  = pix_seen;
    done_base = done_seen;
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 50);
    applyStimulus(1'b0, 1'b0, 1);
    waitDone(done_base + 1, 1000);
    checkOutput("endrop_done", 32'(done_seen - done_base), 32'd1);
    checkOutput("endrop_pix", 32'(pix_seen - pix_base), 32'd4);
    checkOutput("endrop_addr3", 32'(pix_addr_log[pix_base + 3]), 32'd3);
    checkOutput("endrop_data2", 32'(pix_data_log[pix_base + 2]), 32'hFF);
    tick(3);
    checkOutput("endrop_busy", 32'(BUSY), 32'd0);
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 200);
    checkOutput("endrop_int_ignored_rises", 32'(bit_idx), 32'd32);
    checkOutput("endrop_int_ignored_busy", 32'(BUSY), 32'd0);
    checkOutput("endrop_int_ignored_done", 32'(done_seen - done_base), 32'd1);

    checkOutput("valid_done_exclusive", 32'(both_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
